// File: rtl/axi_pkg.sv
// Shared types and constants for the single-beat AXI master: FSM state
// encoding, response codes, and a helper that marks the watchdog-guarded states.
package axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_TIMEOUT = 2'b10;
  localparam logic [1:0] RESP_ERR     = 2'b11;

  function automatic logic is_wait_state(input state_e s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == WR_RESP) ||
           (s == RD_ADDR) || (s == RD_DATA);
  endfunction

endpackage

// File: rtl/axi_master_timer.sv
// Per-phase watchdog: a 16-bit counter that restarts on clear and flags
// expiry on the TIMEOUT-th enabled cycle.
module axi_master_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // NOTE: state updates use non-blocking assignments; reset is synchronous, so it is sampled like any other input.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/axi_master.sv
// Single-outstanding AXI4-Lite style master: accepts one local command,
// runs it over AW/W/B or AR/R, and returns a registered completion.
module axi_master
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              awvalid,
  output logic [ADDR_W-1:0] awaddr,
  input  logic              awready,
  output logic              wvalid,
  output logic [DATA_W-1:0] wdata,
  input  logic              wready,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready,
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  output logic              rready
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                cmd_ready_q, awvalid_q, wvalid_q, bready_q;
  logic                arvalid_q, rready_q, rsp_valid_q;
  logic                awaited, expired;

  axi_master_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (aclk),
    .rst_ni    (arst),
    .clear_i   (state_d != state_q),
    .enable_i  (is_wait_state(state_q)),
    .expired_o (expired)
  );

  always_comb begin
    unique case (state_q)
      WR_ADDR: awaited = awready;
      WR_DATA: awaited = wready;
      WR_RESP: awaited = bvalid;
      RD_ADDR: awaited = arready;
      RD_DATA: awaited = rvalid;
      default: awaited = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    // A slave handshake on the expiry cycle takes priority over the timeout.
    if (is_wait_state(state_q) && !awaited && expired) begin
      state_d     = DONE;
      rsp_resp_d  = RESP_TIMEOUT;
      rsp_rdata_d = '0;
    end else begin
      unique case (state_q)
        IDLE: if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = cmd_write ? WR_ADDR : RD_ADDR;
        end
        WR_ADDR: if (awready) state_d = WR_DATA;
        WR_DATA: if (wready)  state_d = WR_RESP;
        WR_RESP: if (bvalid) begin
          rsp_resp_d  = bresp;
          rsp_rdata_d = '0;
          state_d     = DONE;
        end
        RD_ADDR: if (arready) state_d = RD_DATA;
        RD_DATA: if (rvalid) begin
          rsp_resp_d  = rresp;
          rsp_rdata_d = rresp[1] ? '0 : rdata;
          state_d     = DONE;
        end
        DONE:    if (rsp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!arst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Handshake outputs are registered from the next state; cmd_ready waits one
  // full IDLE cycle so acceptances are never back-to-back.
  always_ff @(posedge aclk) begin
    if (!arst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      cmd_ready_q <= (state_q == IDLE) && (state_d == IDLE);
      awvalid_q   <= (state_d == WR_ADDR);
      wvalid_q    <= (state_d == WR_DATA);
      bready_q    <= (state_d == WR_RESP);
      arvalid_q   <= (state_d == RD_ADDR);
      rready_q    <= (state_d == RD_DATA);
      rsp_valid_q <= (state_d == DONE);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = addr_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_axi_master.sv
// Directed bench for axi_master with a small behavioural slave: addresses
// below 0x100 hit a 64-word memory, anything above answers with error 11.
module tb_axi_master;
  import axi_pkg::*;

  logic        aclk = 1'b0;
  logic        arst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [1:0]  bresp, rresp;

  axi_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .aclk(aclk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
  );

  always #5 aclk = ~aclk;

  // Slave model
  int          aw_delay = 0;
  logic        w_stall = 1'b0, r_stall = 1'b0;
  int          aw_hi_cnt = 0;
  logic [23:0] hs_log = '0;
  logic        overlap_seen = 1'b0;
  logic [31:0] wr_addr_lat = '0, rd_addr_lat = '0;
  logic [31:0] mem [64];

  assign awready = awvalid && (aw_hi_cnt >= aw_delay);
  assign wready  = wvalid && !w_stall;
  assign bvalid  = bready;
  assign bresp   = (wr_addr_lat < 32'h100) ? 2'b00 : 2'b11;
  assign arready = arvalid;
  assign rvalid  = rready && !r_stall;
  assign rresp   = (rd_addr_lat < 32'h100) ? 2'b00 : 2'b11;
  assign rdata   = (rd_addr_lat < 32'h100) ? mem[rd_addr_lat[7:2]] : 32'hBAD0_BAD0;

  always @(posedge aclk) begin
    if (cmd_valid && cmd_ready) begin
      aw_hi_cnt <= 0;
      hs_log    <= '0;
    end else if (awvalid) begin
      aw_hi_cnt <= aw_hi_cnt + 1;
    end
    if (awvalid && awready) begin
      wr_addr_lat <= awaddr;
      hs_log      <= {hs_log[15:0], 8'h41};
    end
    if (wvalid && wready) begin
      if (wr_addr_lat < 32'h100) mem[wr_addr_lat[7:2]] <= wdata;
      hs_log <= {hs_log[15:0], 8'h57};
    end
    if (bvalid && bready) hs_log <= {hs_log[15:0], 8'h42};
    if (arvalid && arready) rd_addr_lat <= araddr;
    if (awvalid && wvalid) overlap_seen <= 1'b1;
  end

  logic [136:0] all_outs;
  assign all_outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, awvalid, awaddr,
                     wvalid, wdata, bready, arvalid, araddr, rready};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output logic [31:0] rd, output logic [1:0] rs,
                          output logic stable, output logic turn_rdy);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check("rsp_valid_wait", rsp_valid, 1'b1);
    rd = rsp_rdata;
    rs = rsp_resp;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge aclk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rs || cmd_ready !== 1'b0)
        stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    turn_rdy = cmd_ready | rsp_valid;
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input int hold,
                         output logic [31:0] rd, output logic [1:0] rs,
                         output logic stable, output logic turn_rdy);
    start_cmd(wr, a, d);
    wait_rsp(hold, rd, rs, stable, turn_rdy);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        st, tr, quiet;
    int          n;

    // Reset state and release
    repeat (3) @(negedge aclk);
    check("reset_outputs_zero", all_outs, '0);
    arst = 1'b1;
    @(negedge aclk);
    check("cmd_ready_after_release", cmd_ready, 1'b1);

    // Write 0x10 then read it back
    run_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 0, rd, rs, st, tr);
    check("wr10_resp", rs, RESP_OKAY);
    check("wr10_rdata", rd, 32'h0);
    check("wr10_hs_order", hs_log, 24'h41_57_42);
    check("turnaround_idle_gap", tr, 1'b0);

    run_cmd(1'b0, 32'h10, 32'h0, 0, rd, rs, st, tr);
    check("rd10_rdata", rd, 32'hDEAD_BEEF);
    check("rd10_resp", rs, RESP_OKAY);

    // Slave error passthrough
    run_cmd(1'b1, 32'h200, 32'h1111_2222, 0, rd, rs, st, tr);
    check("wr200_resp", rs, RESP_ERR);
    run_cmd(1'b0, 32'h200, 32'h0, 0, rd, rs, st, tr);
    check("rd200_resp", rs, RESP_ERR);
    check("rd200_rdata", rd, 32'h0);

    // awready arrives on the expiry cycle: handshake wins
    aw_delay = 15;
    run_cmd(1'b1, 32'h20, 32'h1234_5678, 0, rd, rs, st, tr);
    check("aw_edge_resp", rs, RESP_OKAY);
    check("aw_edge_cycles", aw_hi_cnt, 16);
    check("aw_edge_hs_order", hs_log, 24'h41_57_42);

    // awready never arrives: timeout after 16 wait cycles
    aw_delay = 1000;
    run_cmd(1'b1, 32'h24, 32'hCAFE_F00D, 0, rd, rs, st, tr);
    check("aw_to_resp", rs, RESP_TIMEOUT);
    check("aw_to_rdata", rd, 32'h0);
    check("aw_to_awvalid_cycles", aw_hi_cnt, 16);
    check("aw_to_no_handshake", hs_log, 24'h0);
    aw_delay = 0;

    run_cmd(1'b0, 32'h20, 32'h0, 0, rd, rs, st, tr);
    check("after_to_rdata", rd, 32'h1234_5678);
    check("after_to_resp", rs, RESP_OKAY);

    // Read data never arrives
    r_stall = 1'b1;
    run_cmd(1'b0, 32'h10, 32'h0, 0, rd, rs, st, tr);
    check("r_to_resp", rs, RESP_TIMEOUT);
    check("r_to_rdata", rd, 32'h0);
    r_stall = 1'b0;

    // Completion held off for 10 cycles
    run_cmd(1'b0, 32'h10, 32'h0, 10, rd, rs, st, tr);
    check("hold_stable", st, 1'b1);
    check("hold_rdata", rd, 32'hDEAD_BEEF);

    // Reset while in WR_DATA
    w_stall = 1'b1;
    start_cmd(1'b1, 32'h30, 32'h5555_AAAA);
    n = 0;
    while (wvalid !== 1'b1 && n < 10) begin
      @(negedge aclk);
      n++;
    end
    check("wvalid_seen", wvalid, 1'b1);
    arst = 1'b0;
    @(negedge aclk);
    check("midrst_outputs_zero", all_outs, '0);
    arst = 1'b1;
    w_stall = 1'b0;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      if (rsp_valid !== 1'b0 || wvalid !== 1'b0) quiet = 1'b0;
    end
    check("midrst_no_rsp", quiet, 1'b1);

    run_cmd(1'b0, 32'h10, 32'h0, 0, rd, rs, st, tr);
    check("post_rst_rdata", rd, 32'hDEAD_BEEF);
    check("post_rst_resp", rs, RESP_OKAY);

    check("aw_w_never_overlap", overlap_seen, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
